// File: rtl/ref_cache_line_fetch_scheduler.sv
// ref_cache_line_fetch_scheduler
// Sequencer in front of the reference-pixel cache tag lookup. It accepts one
// reference block (top-left pixel, width-1, height-1), works out how many
// cache lines the block covers horizontally and vertically, and then issues
// one cache-line request per covered line in raster order.
//
// Ports:
//   clk, reset_n      clock (rising edge) and asynchronous active-low reset
//   blk_valid_in      block request valid
//   blk_ready_out     scheduler idle and able to take a block
//   start_x_in/_y_in  top-left pixel coordinate of the block
//   rf_blk_wdt_in     block width minus 1
//   rf_blk_hgt_in     block height minus 1
//   cl_valid_out      cache-line request valid
//   cl_ready_in       downstream consumes the current line request
//   cl_x_out/_y_out   cache-line column / row index
//   cl_last_out       current request is the final line of the block
//   cl_cnt_out        number of lines in the block, (dx+1)*(dy+1)
//   blk_done_out      one-cycle pulse after the final line is consumed
module ref_cache_line_fetch_scheduler #(
    parameter int C_L_H_SIZE = 3,
    parameter int C_L_V_SIZE = 2,
    parameter int DIM_WDTH   = 4,
    parameter int PIC_X_WDTH = 12,
    parameter int PIC_Y_WDTH = 12
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           blk_valid_in,
    output logic                           blk_ready_out,
    input  logic [PIC_X_WDTH-1:0]          start_x_in,
    input  logic [PIC_Y_WDTH-1:0]          start_y_in,
    input  logic [DIM_WDTH-1:0]            rf_blk_wdt_in,
    input  logic [DIM_WDTH-1:0]            rf_blk_hgt_in,
    output logic                           cl_valid_out,
    input  logic                           cl_ready_in,
    output logic [PIC_X_WDTH-C_L_H_SIZE-1:0] cl_x_out,
    output logic [PIC_Y_WDTH-C_L_V_SIZE-1:0] cl_y_out,
    output logic                           cl_last_out,
    output logic [3:0]                     cl_cnt_out,
    output logic                           blk_done_out
);

    localparam int LXW = PIC_X_WDTH - C_L_H_SIZE;
    localparam int LYW = PIC_Y_WDTH - C_L_V_SIZE;
    // Only the low (line size + 2) bits of the end coordinate matter for the
    // modulo-4 line difference, so the adders are kept that narrow.
    localparam int XSW = C_L_H_SIZE + 2;
    localparam int YSW = C_L_V_SIZE + 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LXW-1:0]   lx0_q, lx0_d;
    logic [LYW-1:0]   ly0_q, ly0_d;
    logic [1:0]       dx_q, dx_d;
    logic [1:0]       dy_q, dy_d;
    logic [1:0]       xi_q, xi_d;
    logic [1:0]       yi_q, yi_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [LXW-1:0]   cl_x_q, cl_x_d;
    logic [LYW-1:0]   cl_y_q, cl_y_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [XSW-1:0]   end_x_lo_s;
    logic [YSW-1:0]   end_y_lo_s;
    logic [1:0]       dx_s, dy_s;
    logic [LXW-1:0]   lx0_s;
    logic [LYW-1:0]   ly0_s;
    logic [3:0]       cnt_s;
    logic [1:0]       nxi_s, nyi_s;

    // Span of the incoming block in cache lines (modulo-4 line-index difference).
    always_comb begin
        end_x_lo_s = start_x_in[XSW-1:0] + XSW'(rf_blk_wdt_in);
        end_y_lo_s = start_y_in[YSW-1:0] + YSW'(rf_blk_hgt_in);
        dx_s       = end_x_lo_s[XSW-1:C_L_H_SIZE] - start_x_in[XSW-1:C_L_H_SIZE];
        dy_s       = end_y_lo_s[YSW-1:C_L_V_SIZE] - start_y_in[YSW-1:C_L_V_SIZE];
        lx0_s      = start_x_in[PIC_X_WDTH-1:C_L_H_SIZE];
        ly0_s      = start_y_in[PIC_Y_WDTH-1:C_L_V_SIZE];
        cnt_s      = (4'(dx_s) + 4'd1) * (4'(dy_s) + 4'd1);
    end

    // Raster-order successor of the current line offset.
    always_comb begin
        if (xi_q == dx_q) begin
            nxi_s = 2'd0;
            nyi_s = yi_q + 2'd1;
        end else begin
            nxi_s = xi_q + 2'd1;
            nyi_s = yi_q;
        end
    end

    // Next-state and registered-output computation of the issue FSM.
    always_comb begin
        state_d = state_q;
        lx0_d   = lx0_q;
        ly0_d   = ly0_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        xi_d    = xi_q;
        yi_d    = yi_q;
        ready_d = ready_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cl_x_d  = cl_x_q;
        cl_y_d  = cl_y_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (blk_valid_in && ready_q) begin
                    state_d = ST_ISSUE;
                    lx0_d   = lx0_s;
                    ly0_d   = ly0_s;
                    dx_d    = dx_s;
                    dy_d    = dy_s;
                    xi_d    = 2'd0;
                    yi_d    = 2'd0;
                    ready_d = 1'b0;
                    valid_d = 1'b1;
                    cl_x_d  = lx0_s;
                    cl_y_d  = ly0_s;
                    last_d  = (dx_s == 2'd0) && (dy_s == 2'd0);
                    cnt_d   = cnt_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cl_ready_in) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        xi_d   = nxi_s;
                        yi_d   = nyi_s;
                        cl_x_d = lx0_q + LXW'(nxi_s);
                        cl_y_d = ly0_q + LYW'(nyi_s);
                        last_d = (nxi_s == dx_q) && (nyi_s == dy_q);
                    end
                end else begin
                    // Stalled: every cl_* output holds.
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            lx0_q   <= {LXW{1'b0}};
            ly0_q   <= {LYW{1'b0}};
            dx_q    <= 2'd0;
            dy_q    <= 2'd0;
            xi_q    <= 2'd0;
            yi_q    <= 2'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            cl_x_q  <= {LXW{1'b0}};
            cl_y_q  <= {LYW{1'b0}};
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            lx0_q   <= lx0_d;
            ly0_q   <= ly0_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            xi_q    <= xi_d;
            yi_q    <= yi_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cl_x_q  <= cl_x_d;
            cl_y_q  <= cl_y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign blk_ready_out = ready_q;
    assign cl_valid_out  = valid_q;
    assign cl_last_out   = last_q;
    assign blk_done_out  = done_q;
    assign cl_x_out      = cl_x_q;
    assign cl_y_out      = cl_y_q;
    assign cl_cnt_out    = cnt_q;

endmodule

// File: tb/tb_ref_cache_line_fetch_scheduler.sv
// Bench for ref_cache_line_fetch_scheduler: a table of directed blocks,
// a backpressure run, a mid-block reset sequence and randomized blocks, all
// checked against a line list computed from pixel geometry.
module tb_ref_cache_line_fetch_scheduler;

    logic        clk;
    logic        reset_n;
    logic        blk_valid_in;
    logic        blk_ready_out;
    logic [11:0] start_x_in;
    logic [11:0] start_y_in;
    logic [3:0]  rf_blk_wdt_in;
    logic [3:0]  rf_blk_hgt_in;
    logic        cl_valid_out;
    logic        cl_ready_in;
    logic [8:0]  cl_x_out;
    logic [9:0]  cl_y_out;
    logic        cl_last_out;
    logic [3:0]  cl_cnt_out;
    logic        blk_done_out;

    int n_cmp;
    int n_bad;

    ref_cache_line_fetch_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .blk_valid_in  (blk_valid_in),
        .blk_ready_out (blk_ready_out),
        .start_x_in    (start_x_in),
        .start_y_in    (start_y_in),
        .rf_blk_wdt_in (rf_blk_wdt_in),
        .rf_blk_hgt_in (rf_blk_hgt_in),
        .cl_valid_out  (cl_valid_out),
        .cl_ready_in   (cl_ready_in),
        .cl_x_out      (cl_x_out),
        .cl_y_out      (cl_y_out),
        .cl_last_out   (cl_last_out),
        .cl_cnt_out    (cl_cnt_out),
        .blk_done_out  (blk_done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sx; int sy; int w; int h;
        int cnt; int lx; int ly; int mode;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
    // abort_at > 0 returns right after that many transfers have been granted.
    task automatic run_block(input int sx, input int sy, input int w, input int h,
                             input int mode, input int abort_at,
                             output int nx, output int lxo, output int lyo, output int cnto);
        int ex[$];
        int ey[$];
        int lx0, ly0, ncol, nrow, n, k, budget;
        int px, py, pl;
        bit stall, fin, rdy;
        // Reference: lines covered by pixels sx..sx+w, sy..sy+h, raster order.
        lx0  = sx / 8;
        ly0  = sy / 4;
        ncol = ((sx % 8) + w) / 8 + 1;
        nrow = ((sy % 4) + h) / 4 + 1;
        for (int r = 0; r < nrow; r++)
            for (int c = 0; c < ncol; c++) begin
                ex.push_back((lx0 + c) % 512);
                ey.push_back((ly0 + r) % 1024);
            end
        n = ex.size();
        nx = 0; lxo = -1; lyo = -1; cnto = -1;
        budget = 0;
        while (!blk_ready_out && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("blk_ready_idle", int'(blk_ready_out), 1);
        blk_valid_in  = 1'b1;
        start_x_in    = 12'(sx);
        start_y_in    = 12'(sy);
        rf_blk_wdt_in = 4'(w);
        rf_blk_hgt_in = 4'(h);
        cl_ready_in   = 1'b0;
        @(negedge clk);
        blk_valid_in  = 1'b0;
        k = 0; stall = 1'b0; fin = 1'b0; px = 0; py = 0; pl = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (!cl_valid_out) begin
                chk("cl_valid_during_block", 0, 1);
                break;
            end
            chk("blk_ready_busy", int'(blk_ready_out), 0);
            chk("blk_done_early", int'(blk_done_out), 0);
            if (stall) begin
                chk("stall_x", int'(cl_x_out), px);
                chk("stall_y", int'(cl_y_out), py);
                chk("stall_last", int'(cl_last_out), pl);
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            cl_ready_in = rdy;
            if (rdy) begin
                chk("line_x", int'(cl_x_out), ex[k]);
                chk("line_y", int'(cl_y_out), ey[k]);
                chk("line_last", int'(cl_last_out), (k == n - 1) ? 1 : 0);
                chk("line_cnt", int'(cl_cnt_out), n);
                lxo = int'(cl_x_out);
                lyo = int'(cl_y_out);
                k++;
                nx = k;
                if (k == n) fin = 1'b1;
                if (abort_at > 0 && k == abort_at) return;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
                px = int'(cl_x_out);
                py = int'(cl_y_out);
                pl = int'(cl_last_out);
            end
            @(negedge clk);
        end
        if (!fin) chk("block_timeout", 0, 1);
        cl_ready_in = 1'b0;
        chk("blk_done_pulse", int'(blk_done_out), 1);
        chk("cl_valid_after_last", int'(cl_valid_out), 0);
        chk("blk_ready_after_last", int'(blk_ready_out), 1);
        @(negedge clk);
        chk("blk_done_one_cycle", int'(blk_done_out), 0);
        cnto = int'(cl_cnt_out);
    endtask

    initial begin
        int nx, lx, ly, cnt;
        int sx, sy, w, h;
        n_cmp = 0;
        n_bad = 0;
        reset_n       = 1'b0;
        blk_valid_in  = 1'b0;
        cl_ready_in   = 1'b0;
        start_x_in    = 12'd0;
        start_y_in    = 12'd0;
        rf_blk_wdt_in = 4'd0;
        rf_blk_hgt_in = 4'd0;

        //          sx    sy  w   h   cnt lx   ly mode
        tbl[0] = '{   5,   2, 10,  6,  6,   1,  2, 0};
        tbl[1] = '{  16,   8,  7,  3,  1,   2,  2, 0};
        tbl[2] = '{   7,   3, 11, 11, 12,   2,  3, 0};
        tbl[3] = '{   5,   2, 10,  6,  6,   1,  2, 1};
        tbl[4] = '{4090,   0, 10,  0,  2,   0,  0, 0};

        repeat (2) @(negedge clk);
        chk("rst_blk_ready", int'(blk_ready_out), 1);
        chk("rst_cl_valid", int'(cl_valid_out), 0);
        chk("rst_cl_last", int'(cl_last_out), 0);
        chk("rst_blk_done", int'(blk_done_out), 0);
        chk("rst_cl_x", int'(cl_x_out), 0);
        chk("rst_cl_y", int'(cl_y_out), 0);
        chk("rst_cl_cnt", int'(cl_cnt_out), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_block(tbl[i].sx, tbl[i].sy, tbl[i].w, tbl[i].h, tbl[i].mode, 0,
                      nx, lx, ly, cnt);
            chk("tbl_nlines", nx, tbl[i].cnt);
            chk("tbl_cnt_hold", cnt, tbl[i].cnt);
            chk("tbl_last_x", lx, tbl[i].lx);
            chk("tbl_last_y", ly, tbl[i].ly);
        end

        // Reset after two of six lines are granted.
        run_block(5, 2, 10, 6, 0, 2, nx, lx, ly, cnt);
        chk("abort_granted", nx, 2);
        @(negedge clk);
        reset_n = 1'b0;
        cl_ready_in = 1'b0;
        #1;
        chk("midrst_cl_valid", int'(cl_valid_out), 0);
        chk("midrst_blk_ready", int'(blk_ready_out), 1);
        chk("midrst_cl_last", int'(cl_last_out), 0);
        chk("midrst_cl_cnt", int'(cl_cnt_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_no_valid", int'(cl_valid_out), 0);
        run_block(16, 8, 7, 3, 0, 0, nx, lx, ly, cnt);
        chk("postrst_nlines", nx, 1);
        chk("postrst_x", lx, 2);
        chk("postrst_y", ly, 2);

        // Randomized in-contract blocks with random backpressure.
        for (int i = 0; i < 40; i++) begin
            sx = int'($urandom_range(0, 4095));
            sy = int'($urandom_range(0, 4095));
            w  = int'($urandom_range(0, 11));
            h  = int'($urandom_range(0, 11));
            run_block(sx, sy, w, h, 2, 0, nx, lx, ly, cnt);
            chk("rnd_nlines", nx, (((sx % 8) + w) / 8 + 1) * (((sy % 4) + h) / 4 + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ref_cache_line_fetch_scheduler.md
Name: ref_cache_line_fetch_scheduler

Overview:
- Sequencer in front of the reference-pixel cache tag lookup.
- Accepts one reference-block request (top-left pixel, width-1, height-1) from the MV/prediction front end.
- Computes the horizontal and vertical span in cache lines, using the same modulo-4 line-index difference arithmetic as the cache's valid-line counter.
- Issues one cache-line request per covered line, in raster order, over a valid/ready handshake. A new block is accepted only after the last line request is consumed.

Parameters:
- C_L_H_SIZE, 3, log2 of cache-line width in pixels (8)
- C_L_V_SIZE, 2, log2 of cache-line height in rows (4)
- DIM_WDTH, 4, width of block dimension inputs
- PIC_X_WDTH, 12, pixel x coordinate width
- PIC_Y_WDTH, 12, pixel y coordinate width

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- blk_valid_in  in  1  block request valid
- blk_ready_out  out  1  scheduler can accept a block
- start_x_in  in  PIC_X_WDTH  top-left pixel x
- start_y_in  in  PIC_Y_WDTH  top-left pixel y
- rf_blk_wdt_in  in  DIM_WDTH  block width minus 1 (max 11)
- rf_blk_hgt_in  in  DIM_WDTH  block height minus 1 (max 11)
- cl_valid_out  out  1  cache-line request valid
- cl_ready_in  in  1  downstream accepts line request
- cl_x_out  out  PIC_X_WDTH-C_L_H_SIZE  cache-line column index
- cl_y_out  out  PIC_Y_WDTH-C_L_V_SIZE  cache-line row index
- cl_last_out  out  1  final line of current block
- cl_cnt_out  out  4  total lines of current block, (dx+1)*(dy+1)
- blk_done_out  out  1  one-cycle pulse when last line is accepted

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; blk_ready_out=1.
  - cl_valid_out, cl_last_out and blk_done_out are 0.
  - cl_x_out, cl_y_out and cl_cnt_out are 0.
  - All counters are 0.
- Reset mid-block discards the block; no further line requests are issued.
- Span arithmetic (combinational on inputs, registered on accept):
  - end_x = start_x_in + rf_blk_wdt_in, truncated to PIC_X_WDTH. end_y is computed the same way.
  - lx0 = start_x_in >> C_L_H_SIZE; ly0 = start_y_in >> C_L_V_SIZE.
  - dx = (end_x[C_L_H_SIZE+1:C_L_H_SIZE] - start_x_in[C_L_H_SIZE+1:C_L_H_SIZE]) mod 4. dy is computed analogously.
  - With the stated maxima, dx is in 0..2 and dy is in 0..3. Inputs above 11 are out of contract; behaviour is modulo-4, with no error.
- FSM:
  - IDLE: blk_ready_out=1; cl_valid_out=0.
    - On blk_valid_in & blk_ready_out: latch lx0, ly0, dx, dy; set cl_cnt_out; clear xi, yi; go to ISSUE.
  - ISSUE: blk_ready_out=0; cl_valid_out=1.
    - cl_x_out = lx0+xi and cl_y_out = ly0+yi, both wrapping modulo 2^width (picture-edge wrap is allowed).
    - cl_last_out = (xi==dx)&(yi==dy).
  - On cl_valid_out & cl_ready_in:
    - If not last: if xi==dx then xi=0 and yi++, else xi++.
    - If last: pulse blk_done_out the next cycle, return to IDLE, and set cl_valid_out=0 in the same cycle.
- Handshake and timing:
  - The first line request appears the cycle after block accept.
  - Throughput is one line per cycle while cl_ready_in=1.
  - With cl_ready_in=0, cl_valid_out and all cl_* outputs hold stable.
  - cl_valid_out never depends combinationally on cl_ready_in.
- blk_ready_out rises the cycle after the last accept. There is no back-to-back block overlap, so at least one idle cycle occurs between blocks.
- cl_cnt_out holds its value until the next block accept.

Test Plan:
- Start (5,2), wdt 10, hgt 6, ready=1:
  - dx=1, dy=2, cl_cnt=6.
  - Lines (0,0),(1,0),(0,1),(1,1),(0,2),(1,2) on consecutive cycles; last only on (1,2).
  - blk_done pulse the following cycle.
- Aligned block start (16,8), wdt 7, hgt 3 -> single line (2,2) with cl_last=1 on the first valid cycle; cl_cnt=1.
- Max span start (7,3), wdt 11, hgt 11 -> dx=2, dy=3, 12 lines. Last line is (2,3). blk_ready_out stays 0 throughout.
- Backpressure on the 6-line case: toggle cl_ready_in 1,0,0,1,...
  - Outputs are stable while stalled.
  - Exactly 6 accepted transfers, in raster order, with no duplicates or skips.
- Wrap: start_x 4090, wdt 10, start_y 0, hgt 0 -> dx=1; lines (511,0) then (0,0).
- Assert reset_n=0 after 2 of 6 lines are accepted:
  - cl_valid_out drops asynchronously; blk_ready_out=1.
  - A new block (16,8,7,3) afterwards yields only (2,2).
